register_file: RTL and testbench
================================

# register_file

16-entry, DATA_W-bit general-purpose register file with two combinational read ports and one synchronous write port. Sits directly downstream of the 4-to-16 destination-register decoder. The decoder's one-hot `decOut` vector is consumed as the per-register write-select, so each register's write enable is one decoder bit ANDed with `regWrite`. Also reports illegal (non-one-hot) write selects through a sticky error flag.

## Interface
Parameters:
- `DATA_W`, default 32: width of each register and of the data ports.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high. Clears all registers and `wrErr`.
- `regWrite`  input  1: write request, qualifies `decOut`.
- `decOut`  input  16: one-hot destination select from the decoder. Bit i selects register i.
- `writeData`  input  DATA_W: data to be written.
- `srcReg1`  input  4: read port 1 address.
- `srcReg2`  input  4: read port 2 address.
- `regData1`  output  DATA_W: contents of register `srcReg1`.
- `regData2`  output  DATA_W: contents of register `srcReg2`.
- `wrErr`  output  1: sticky flag, set when a write is requested with a non-one-hot `decOut`.

## Operation
- Storage: 16 registers, `reg[0]`..`reg[15]`, each DATA_W bits. All registers are writable; there is no hardwired-zero register.
- Legal write: `regWrite`=1 and `decOut` has exactly one bit set.
  - At the clock edge, the selected register loads `writeData`.
  - All other registers hold their value.
- Illegal write: `regWrite`=1 and `decOut` is zero or has two or more bits set.
  - No register changes.
  - `wrErr` is set to 1 at that edge.
- No write: `regWrite`=0.
  - No register changes, whatever `decOut` holds.
  - `wrErr` is unaffected.
- `wrErr` is sticky. Only `reset` clears it.
- Reads: `regDataN` = `reg[srcRegN]`, combinational from current state. Both ports are independent and may address the same register.
- The one-hot check is a popcount==1 test on `decOut`, performed combinationally and used to gate all 16 enables.
- Reset mid-operation: asserting `reset` clears all registers and `wrErr` immediately, without waiting for a clock edge. A write presented in the same cycle as `reset` is discarded.

## Timing
- Write latency: 1 cycle. Data is visible on a read port right after the clock edge that writes it.
- Read latency: 0 cycles (combinational) from `srcRegN` or any register change.
- Read and write to the same register in the same cycle, macro off: the read returns the old value until the edge.
- Reset values:
  - all registers 0, so `regData1`=`regData2`=0;
  - `wrErr`=0.
- After `reset` deasserts, the first clock edge can write.

## Configuration
- Macro: `REGFILE_WRITE_BYPASS_EN`.
- Defined: adds write-to-read forwarding. If `regWrite`=1, `decOut` is legal one-hot and its set bit index equals `srcRegN`, then `regDataN` = `writeData` combinationally in the same cycle. Forwarding is never applied for an illegal `decOut`.
- Undefined: no forwarding. Reads always return stored state.
- Register update timing is identical in both builds.

## Test plan
- Reset then read: assert `reset`, then read all 16 registers on both ports -> every read is 0 and `wrErr`=0.
- Write/read each register: for i=0..15, drive `regWrite`=1, `decOut`=1<<i, `writeData`=0xA5A50000+i for one edge. Then read via `srcReg1`=i and `srcReg2`=15-i -> values 0xA5A50000+i and 0xA5A50000+(15-i) respectively.
- Illegal select: preload reg3=0x11 and reg5=0x22. Write `decOut`=16'h0028 with `writeData`=0xFF -> reg3=0x11, reg5=0x22, `wrErr`=1. Then do a legal write -> `wrErr` stays 1. Write with `decOut`=0 -> no change.
- Gating: `regWrite`=0, `decOut`=16'h0004, `writeData`=0x77 -> reg2 unchanged and `wrErr` unchanged.
- Same-cycle read/write: reg7=0x10, `srcReg1`=7, write 0x20 to reg7.
  - Before the edge, `regData1`=0x10 with the macro undefined, or 0x20 with `REGFILE_WRITE_BYPASS_EN` defined.
  - After the edge, 0x20 in both builds.
- Async reset mid-write: hold a legal write to reg9 and pulse `reset` between clock edges -> reg9 reads 0 immediately, and remains 0 through the next edge while `reset` is high.

Source files
------------

// File: rtl/register_file.sv
// 16 x DATA_W register file: two combinational read ports, one one-hot-selected write port, sticky wrErr on a non-one-hot select.
// Write lands on the rising edge, reads are 0-cycle, no backpressure; `REGFILE_WRITE_BYPASS_EN adds same-cycle write-to-read forwarding.
module register_file #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [15:0]       decOut,
    input  logic [DATA_W-1:0] writeData,
    input  logic [3:0]        srcReg1,
    input  logic [3:0]        srcReg2,
    output logic [DATA_W-1:0] regData1,
    output logic [DATA_W-1:0] regData2,
    output logic              wrErr
);

    logic [DATA_W-1:0] regs [16];
    logic              one_hot;
    logic [15:0]       wr_en;

    // A zero or multi-bit select must never touch storage, so the popcount gates every enable.
    always_comb begin
        one_hot = ($countones(decOut) == 1);
        wr_en   = decOut & {16{regWrite & one_hot}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            wrErr <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= writeData;
                end
            end
            if (regWrite && !one_hot) begin
                wrErr <= 1'b1;
            end
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic [3:0] wr_idx;
    logic       fwd;

    always_comb begin
        wr_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (decOut[i]) begin
                wr_idx = 4'(i);
            end
        end
        fwd = regWrite & one_hot;
    end

    assign regData1 = (fwd && (wr_idx == srcReg1)) ? writeData : regs[srcReg1];
    assign regData2 = (fwd && (wr_idx == srcReg2)) ? writeData : regs[srcReg2];
`else
    assign regData1 = regs[srcReg1];
    assign regData2 = regs[srcReg2];
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, per-register write/read, a vector table of legal/illegal/gated writes, then same-cycle and async-reset sequences.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        regWrite = 1'b0;
    logic [15:0] decOut = '0;
    logic [31:0] writeData = '0;
    logic [3:0]  srcReg1 = '0;
    logic [3:0]  srcReg2 = '0;
    logic [31:0] regData1;
    logic [31:0] regData2;
    logic        wrErr;

    int errors = 0;
    int checks = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam logic [31:0] SAME_PRE  = 32'h20;
    localparam logic [31:0] RST9_PRE  = 32'h5555;
`else
    localparam logic [31:0] SAME_PRE  = 32'h10;
    localparam logic [31:0] RST9_PRE  = 32'hA5A50009;
`endif

    register_file #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .decOut    (decOut),
        .writeData (writeData),
        .srcReg1   (srcReg1),
        .srcReg2   (srcReg2),
        .regData1  (regData1),
        .regData2  (regData2),
        .wrErr     (wrErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] dec;
        logic [31:0] data;
        logic [3:0]  rd1;
        logic [3:0]  rd2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [15:0] d, input logic [31:0] v);
        @(negedge clk);
        regWrite  = w;
        decOut    = d;
        writeData = v;
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        decOut   = '0;
    endtask

    task automatic read_pair(input logic [3:0] a, input logic [3:0] b);
        srcReg1 = a;
        srcReg2 = b;
        #1;
    endtask

    initial begin
        // State carried in from the per-register pass: reg[i] = A5A50000+i.
        vecs[0] = '{1'b1, 16'h0008, 32'h11, 4'd3, 4'd5, 32'h11, 32'hA5A50005, 1'b0};
        vecs[1] = '{1'b1, 16'h0020, 32'h22, 4'd3, 4'd5, 32'h11, 32'h22,       1'b0};
        vecs[2] = '{1'b0, 16'h0004, 32'h77, 4'd2, 4'd2, 32'hA5A50002, 32'hA5A50002, 1'b0};
        vecs[3] = '{1'b0, 16'h0028, 32'hFF, 4'd3, 4'd5, 32'h11, 32'h22,       1'b0};
        vecs[4] = '{1'b1, 16'h0028, 32'hFF, 4'd3, 4'd5, 32'h11, 32'h22,       1'b1};
        vecs[5] = '{1'b1, 16'h0001, 32'h1234, 4'd0, 4'd3, 32'h1234, 32'h11,   1'b1};
        vecs[6] = '{1'b1, 16'h0000, 32'hEE, 4'd0, 4'd5, 32'h1234, 32'h22,     1'b1};

        #1 reset = 1'b1;
        #1;
        check("reset_wrErr", {31'b0, wrErr}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            read_pair(4'(i), 4'(15 - i));
            check("reset_rd1", regData1, 32'h0);
            check("reset_rd2", regData2, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 16'(1 << i), 32'hA5A50000 + 32'(i));
        end
        for (int i = 0; i < 16; i++) begin
            read_pair(4'(i), 4'(15 - i));
            check("wr_each_rd1", regData1, 32'hA5A50000 + 32'(i));
            check("wr_each_rd2", regData2, 32'hA5A50000 + 32'(15 - i));
        end
        check("wr_each_wrErr", {31'b0, wrErr}, 32'h0);

        for (int k = 0; k < 7; k++) begin
            cyc(vecs[k].wr, vecs[k].dec, vecs[k].data);
            read_pair(vecs[k].rd1, vecs[k].rd2);
            check($sformatf("vec%0d_rd1", k), regData1, vecs[k].exp1);
            check($sformatf("vec%0d_rd2", k), regData2, vecs[k].exp2);
            check($sformatf("vec%0d_wrErr", k), {31'b0, wrErr}, {31'b0, vecs[k].exp_err});
        end

        // Same-cycle read/write of reg7.
        cyc(1'b1, 16'h0080, 32'h10);
        @(negedge clk);
        regWrite  = 1'b1;
        decOut    = 16'h0080;
        writeData = 32'h20;
        read_pair(4'd7, 4'd7);
        check("same_pre_rd1", regData1, SAME_PRE);
        check("same_pre_rd2", regData2, SAME_PRE);
        @(posedge clk);
        #1;
        check("same_post_rd1", regData1, 32'h20);
        check("same_post_rd2", regData2, 32'h20);

        // Illegal select that includes reg7 must neither forward nor write.
        @(negedge clk);
        decOut    = 16'h0180;
        writeData = 32'h99;
        #1;
        check("illegal_nofwd", regData1, 32'h20);
        @(posedge clk);
        #1;
        check("illegal_nowr", regData1, 32'h20);
        regWrite = 1'b0;
        decOut   = '0;

        // Async reset in the middle of a held legal write to reg9.
        @(negedge clk);
        regWrite  = 1'b1;
        decOut    = 16'h0200;
        writeData = 32'h5555;
        read_pair(4'd9, 4'd8);
        check("rst9_pre", regData1, RST9_PRE);
        #2 reset = 1'b1;
        #1;
        check("rst9_async", regData1, 32'h0);
        check("rst8_async", regData2, 32'h0);
        check("rst_wrErr", {31'b0, wrErr}, 32'h0);
        @(posedge clk);
        #1;
        check("rst9_edge", regData1, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst9_first_wr", regData1, 32'h5555);
        check("rst_first_wrErr", {31'b0, wrErr}, 32'h0);
        regWrite = 1'b0;
        decOut   = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
